// File: rtl/port_fifo.sv
// Per-port input flit buffer for a router node: registered-state ack, no fall-through,
// with wormhole framing tracking (HEADER ... TAIL) and a sticky framing-error flag.
`timescale 1ns/1ps

package noc_types;
    typedef enum logic [1:0] {
        HEADER = 2'd0,
        BODY   = 2'd1,
        TAIL   = 2'd2,
        RSVD   = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t  flit_type;
        logic [13:0] payload;
    } flit_t;
endpackage

module port_fifo
    import noc_types::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int FLIT_W = $bits(flit_t),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_enable,
    output logic              in_ack,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_enable,
    input  logic              out_ack,
    output logic [CNT_W-1:0]  level,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              frame_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rptr_reg;
    logic [PTR_W-1:0]  wptr_reg;
    logic [CNT_W-1:0]  level_reg;
    logic [CNT_W-1:0]  pkt_cnt_reg;
    logic              frame_err_reg;
    logic              in_pkt_open_reg;

    logic       push;
    logic       pop;
    logic       push_tail;
    logic       pop_tail;
    flit_type_t in_type;
    flit_type_t head_type;

    // Handshake outputs depend only on registered occupancy, never on in_enable/out_ack.
    assign in_ack     = (level_reg != CNT_W'(DEPTH));
    assign out_enable = (level_reg != '0);
    assign out_flit   = out_enable ? mem[rptr_reg] : '0;

    assign push      = in_enable && in_ack;
    assign pop       = out_enable && out_ack;
    assign in_type   = flit_type_t'(in_flit[FLIT_W-1 -: 2]);
    assign head_type = flit_type_t'(mem[rptr_reg][FLIT_W-1 -: 2]);
    assign push_tail = push && (in_type == TAIL);
    assign pop_tail  = pop && (head_type == TAIL);

    assign level     = level_reg;
    assign pkt_cnt   = pkt_cnt_reg;
    assign frame_err = frame_err_reg;

    // Storage is not reset; contents are only observed through the valid window.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_reg] <= in_flit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_reg    <= '0;
            wptr_reg    <= '0;
            level_reg   <= '0;
            pkt_cnt_reg <= '0;
        end else begin
            if (push) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (pop) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            case ({push_tail, pop_tail})
                2'b10:   pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
                2'b01:   pkt_cnt_reg <= pkt_cnt_reg - 1'b1;
                default: pkt_cnt_reg <= pkt_cnt_reg;
            endcase
        end
    end

    // Framing is judged on accepted flits only; offending flits are still stored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_pkt_open_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else if (push) begin
            case (in_type)
                HEADER: begin
                    if (in_pkt_open_reg) begin
                        frame_err_reg <= 1'b1;
                    end
                    in_pkt_open_reg <= 1'b1;
                end
                BODY: begin
                    if (!in_pkt_open_reg) begin
                        frame_err_reg <= 1'b1;
                    end
                end
                TAIL: begin
                    if (!in_pkt_open_reg) begin
                        frame_err_reg <= 1'b1;
                    end
                    in_pkt_open_reg <= 1'b0;
                end
                default: begin
                    in_pkt_open_reg <= in_pkt_open_reg;
                end
            endcase
        end
    end

endmodule
